// File: rtl/rf_pkg.sv
// Shared constants, FSM state type and packed-port helper for the
// pipelined CPU general-purpose register file.
package rf_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRP  = 2;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } rf_state_e;

  // LSB position of port 'port' inside a packed multi-port bus of 'width' bits per port
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: one busy bit per register,
// set by issue, cleared by writeback, flushed by a clear request,
// with NRP combinational lookup ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREG = RF_NREG,
  parameter  int NRP  = RF_NRP,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRP*AW-1:0] look_addr,
  output logic [NRP-1:0]    look_busy
);

  logic [NREG-1:0] busy;

  // Busy vector update; the set is applied last so a newer producer wins over a same-edge clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  // Independent busy lookup for every read port
  always_comb begin
    look_busy = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      look_busy[p] = busy[look_addr[port_lsb(p, AW) +: AW]];
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-read-port register file with pending-write scoreboard and a
// sequential clear sweep (INIT) instead of a bulk array reset, keeping
// the storage array RAM-inferable. r0 reads as zero and is never busy.
// Optional WB-to-read forwarding is enabled by defining RF_BYPASS_EN.
module pipe_regfile
  import rf_pkg::*;
#(
  parameter  int XLEN = RF_XLEN,
  parameter  int NREG = RF_NREG,
  parameter  int NRP  = RF_NRP,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       dbg_sel,
  output logic [XLEN-1:0]     dbg_data
);

  rf_state_e       state, state_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic [XLEN-1:0] rf [NREG];

  logic            idle;
  logic            wr_ok;
  logic            iss_ok;
  logic            sb_flush;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;
  logic [NRP-1:0]  sb_busy;

  // State and sweep pointer; reset restarts the sweep at r1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      ptr   <= AW'(1);
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: sweep r1..r(NREG-1), then idle until a clear request
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == AW'(NREG - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt = INIT;
          ptr_nxt   = AW'(1);
        end
      end
      default: begin
        state_nxt = INIT;
        ptr_nxt   = AW'(1);
      end
    endcase
  end

  // Qualified write/issue/flush strobes; nothing from WB or ID is accepted during the sweep
  always_comb begin
    idle     = (state == IDLE);
    wr_ok    = idle && wr_en && (wr_addr != '0);
    iss_ok   = idle && iss_en && (iss_addr != '0);
    sb_flush = idle && clr_req;
  end

  assign ready = idle;

  // Single array write port shared by the sweep and WB
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = ptr;
    arr_wdata = '0;
    if (!idle) begin
      arr_we = 1'b1;
    end else if (wr_ok) begin
      arr_we    = 1'b1;
      arr_waddr = wr_addr;
      arr_wdata = wr_data;
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (arr_we) rf[arr_waddr] <= arr_wdata;
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (sb_flush),
    .set_en    (iss_ok),
    .set_addr  (iss_addr),
    .clr_en    (wr_ok),
    .clr_addr  (wr_addr),
    .look_addr (rd_addr),
    .look_busy (sb_busy)
  );

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[port_lsb(p, AW) +: AW];

    // Read mux: zero during the sweep and for r0, optional same-cycle WB forwarding
    always_comb begin
      d = '0;
      b = 1'b0;
      if (idle) begin
        if (a != '0) d = rf[a];
        b = sb_busy[p];
`ifdef RF_BYPASS_EN
        if (wr_ok && (a == wr_addr)) begin
          d = wr_data;
          // A same-cycle reissue keeps the register busy despite the forwarded value
          if (!(iss_en && (iss_addr == wr_addr))) b = 1'b0;
        end
`endif
      end
    end

    assign rd_data[port_lsb(p, XLEN) +: XLEN] = d;
    assign rd_busy[p] = b;
  end

  // Debug read straight from the array, never forwarded
  always_comb begin
    dbg_data = '0;
    if (idle && (dbg_sel != '0)) dbg_data = rf[dbg_sel];
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: constant vector table, hand
// sequences for sweep/clear/reset timing and bypass, then random stimulus
// against a behavioural model. Honours RF_BYPASS_EN if defined.
module tb_pipe_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr_req = 1'b0;
  logic                ready;
  logic [NRP*AW-1:0]   rd_addr = '0;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic [AW-1:0]       dbg_sel = '0;
  logic [XLEN-1:0]     dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_rf [NREG];
  bit              m_busy [NREG];
  int              m_left;   // sweep cycles still to go; 0 means ready

  task automatic m_reset();
    m_left = NREG - 1;
    for (int i = 0; i < NREG; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    if (rst) m_reset();
    else if (m_left > 0) m_left--;
    else if (clr_req) m_reset();
    else begin
      if (wr_en && wr_addr != 0) begin
        m_rf[wr_addr]   = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ready", 32'(ready), 32'(m_left == 0));
    for (int p = 0; p < NRP; p++) begin
      int unsigned     a;
      logic [XLEN-1:0] ed;
      logic            eb;
      a  = rd_addr[p*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_left == 0) begin
        ed = m_rf[a];
        eb = m_busy[a];
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr != 0 && a == wr_addr) begin
          ed = wr_data;
          if (!(iss_en && iss_addr == wr_addr)) eb = 1'b0;
        end
`endif
      end
      chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], ed);
      chk($sformatf("rd_busy[%0d]", p), 32'(rd_busy[p]), 32'(eb));
    end
    chk("dbg_data", dbg_data, (m_left == 0) ? m_rf[dbg_sel] : '0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
  endtask

  // Count cycles until ready, optionally pulsing clr_req after pulse_at cycles
  task automatic wait_ready(input string name, input int exp_n, input int pulse_at);
    int n;
    n = 0;
    while (n < NREG + 10) begin
      #1;
      check_model();
      if (ready) break;
      if (n == pulse_at) clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            ie;
    logic [AW-1:0]   ia;
    logic [AW-1:0]   r0;
    logic [AW-1:0]   r1;
    logic [AW-1:0]   ds;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [1:0]      eb;
    logic [XLEN-1:0] ed;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [XLEN-1:0] wd,
                              logic ie, logic [AW-1:0] ia,
                              logic [AW-1:0] r0, logic [AW-1:0] r1, logic [AW-1:0] ds,
                              logic [XLEN-1:0] e0, logic [XLEN-1:0] e1,
                              logic [1:0] eb, logic [XLEN-1:0] ed);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.r0 = r0; v.r1 = r1; v.ds = ds;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            we wa  wd            ie ia  r0 r1 ds  e0            e1            eb     ed
    tbl[0]  = mk(1, 3,  32'hDEADBEEF, 0, 0,  0, 0, 0,  32'h0,        32'h0,        2'b00, 32'h0);
    tbl[1]  = mk(0, 0,  32'h0,        0, 0,  3, 3, 3,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF);
    tbl[2]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  3, 0, 0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0);
    tbl[3]  = mk(0, 0,  32'h0,        0, 0,  0, 3, 0,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0);
    tbl[4]  = mk(0, 0,  32'h0,        1, 9,  9, 1, 9,  32'h0,        32'h0,        2'b00, 32'h0);
    tbl[5]  = mk(0, 0,  32'h0,        0, 0,  9, 9, 9,  32'h0,        32'h0,        2'b11, 32'h0);
    tbl[6]  = mk(1, 9,  32'hA5A5A5A5, 0, 0,  3, 3, 3,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF);
    tbl[7]  = mk(0, 0,  32'h0,        0, 0,  9, 1, 9,  32'hA5A5A5A5, 32'h0,        2'b00, 32'hA5A5A5A5);
    tbl[8]  = mk(1, 9,  32'h11111111, 1, 9,  3, 0, 9,  32'hDEADBEEF, 32'h0,        2'b00, 32'hA5A5A5A5);
    tbl[9]  = mk(0, 0,  32'h0,        0, 0,  9, 0, 9,  32'h11111111, 32'h0,        2'b01, 32'h11111111);
    tbl[10] = mk(0, 0,  32'h0,        1, 0,  0, 0, 0,  32'h0,        32'h0,        2'b00, 32'h0);
    tbl[11] = mk(0, 0,  32'h0,        0, 0,  0, 9, 9,  32'h0,        32'h11111111, 2'b10, 32'h11111111);

    m_reset();

    // Reset sweep with WB writing r5 throughout INIT
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFFFFFF;
    rd_addr = {5'd5, 5'd5}; dbg_sel = 5'd5;
    tick();
    tick();
    chk("ready_in_reset", 32'(ready), 32'(0));
    rst = 1'b0;
    wait_ready("reset_sweep_len", NREG - 1, -1);
    wr_en = 1'b0;
    #1;
    chk("r5_after_sweep", rd_data[0 +: XLEN], 32'h0);
    check_model();
    tick();

    // Constant vector table
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia;
      rd_addr = {tbl[i].r1, tbl[i].r0}; dbg_sel = tbl[i].ds;
      #1;
      chk($sformatf("tbl%0d_rd0", i), rd_data[0 +: XLEN], tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rd_data[XLEN +: XLEN], tbl[i].e1);
      chk($sformatf("tbl%0d_busy", i), 32'(rd_busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_dbg", i), dbg_data, tbl[i].ed);
      tick();
    end
    idle_inputs();

    // Bypass: r7 busy, then written while port1 reads it
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_addr = {5'd7, 5'd3}; dbg_sel = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_data", rd_data[XLEN +: XLEN], 32'h12345678);
    chk("bypass_busy", 32'(rd_busy[1]), 32'(0));
`else
    chk("nobypass_data", rd_data[XLEN +: XLEN], 32'h0);
    chk("nobypass_busy", 32'(rd_busy[1]), 32'(1));
`endif
    chk("bypass_dbg_old", dbg_data, 32'h0);
    check_model();
    tick();
    idle_inputs();
    #1;
    chk("after_write_r7", rd_data[XLEN +: XLEN], 32'h12345678);
    chk("after_write_busy", 32'(rd_busy[1]), 32'(0));
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_reissue_data", rd_data[XLEN +: XLEN], 32'hCAFEF00D);
`else
    chk("nobypass_reissue_data", rd_data[XLEN +: XLEN], 32'h12345678);
`endif
    chk("reissue_busy", 32'(rd_busy[1]), 32'(1));
    tick();
    idle_inputs();
    #1;
    chk("reissue_busy_next", 32'(rd_busy[1]), 32'(1));
    check_model();

    // Clear mid-run with a redundant clear pulse during the sweep
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h5;
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle_inputs();
    rd_addr = {5'd6, 5'd4}; dbg_sel = 5'd4;
    #1;
    chk("r4_before_clear", rd_data[0 +: XLEN], 32'h5);
    chk("r6_busy_before_clear", 32'(rd_busy[1]), 32'(1));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_ready("clear_sweep_len", NREG - 1, 10);
    #1;
    chk("r4_after_clear", rd_data[0 +: XLEN], 32'h0);
    chk("r6_busy_after_clear", 32'(rd_busy[1]), 32'(0));

    // Asynchronous reset at ptr=10 restarts the sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    m_reset();
    #1;
    chk("ready_async_rst", 32'(ready), 32'(0));
    tick();
    rst = 1'b0;
    wait_ready("rst_mid_sweep_len", NREG - 1, -1);
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 7));
      for (int p = 0; p < NRP; p++) begin
        rd_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 7));
      end
      dbg_sel  = AW'($urandom_range(0, 7));
      clr_req  = ($urandom_range(0, 149) == 0);
      #1;
      check_model();
      tick();
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
